fifo_wr_ingress: RTL and testbench

- Write-side front end of the async FIFO, directly upstream of the write-pointer/full stage.
- Accepts a valid/ready stream from the producer and buffers it in a 2-entry skid buffer.
- Drives winc/wdata into the FIFO, qualified by wfull.
- Computes a registered fill level and almost-full flag from the write-domain Gray pointers (wptr, wq2_rptr).

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_gray2bin.sv | 20 ++
 rtl/fifo_wr_ingress.sv | 106 ++++++++++
 tb/tb_fifo_wr_ingress.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default sizes, pointer type, Gray decode.
package fifo_pkg;

    localparam int unsigned FIFO_ADDR_SIZE = 4;
    localparam int unsigned FIFO_DATA_SIZE = 8;
    localparam int unsigned FIFO_PTR_W     = FIFO_ADDR_SIZE + 1;

    typedef logic [FIFO_PTR_W-1:0] ptr_t;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[FIFO_PTR_W-1] = g[FIFO_PTR_W-1];
        for (int i = int'(FIFO_PTR_W) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter of parameterised width (XOR prefix from MSB).
module fifo_gray2bin
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_PTR_W
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Running XOR from the MSB down.
    always_comb begin
        bin = '0;
        bin[WIDTH-1] = gray[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
    end

endmodule

// File: rtl/fifo_wr_ingress.sv
// Write-side ingress of the async FIFO: 2-entry skid buffer feeding winc/wdata,
// plus a registered fill level / almost-full flag from the write-domain Gray pointers.
// Optional level logic is enabled by defining FIFO_WR_AFULL_EN; otherwise wlevel and
// walmost_full are tied low and the pointer inputs are ignored.
module fifo_wr_ingress
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_SIZE    = FIFO_ADDR_SIZE,
    parameter int unsigned DATA_SIZE    = FIFO_DATA_SIZE,
    parameter int unsigned AFULL_THRESH = 12
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    input  logic                 s_valid,
    input  logic [DATA_SIZE-1:0] s_data,
    output logic                 s_ready,
    input  logic                 wfull,
    input  logic [ADDR_SIZE:0]   wptr,
    input  logic [ADDR_SIZE:0]   wq2_rptr,
    output logic                 winc,
    output logic [DATA_SIZE-1:0] wdata,
    output logic [ADDR_SIZE:0]   wlevel,
    output logic                 walmost_full
);

    localparam int unsigned PW = ADDR_SIZE + 1;

    logic [DATA_SIZE-1:0] mem [2];
    logic [1:0]           count;
    logic [1:0]           count_next;
    logic                 head;
    logic                 head_next;
    logic                 push;
    logic                 pop;
    logic                 wr_idx;

    assign push   = s_valid && s_ready;
    assign pop    = winc;
    assign winc   = (count != 2'd0) && !wfull;
    assign wdata  = mem[head];
    // Tail slot is head+count mod 2; with count==1 and a pop this is head+1, the same slot.
    assign wr_idx = head ^ count[0];

    // Next count/head from push and pop.
    always_comb begin
        count_next = count;
        head_next  = head;
        if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (pop && !push) begin
            count_next = count - 2'd1;
            head_next  = ~head;
        end else if (pop && push) begin
            head_next  = ~head;
        end
    end

    // Buffer control state and registered ready.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            count   <= 2'd0;
            head    <= 1'b0;
            s_ready <= 1'b0;
        end else begin
            count   <= count_next;
            head    <= head_next;
            s_ready <= (count_next != 2'd2);
        end
    end

    // Storage write; contents need no reset.
    always_ff @(posedge wclk) begin
        if (wrst_n && push) begin
            mem[wr_idx] <= s_data;
        end
    end

`ifdef FIFO_WR_AFULL_EN
    logic [PW-1:0] wbin;
    logic [PW-1:0] rbin;
    logic [PW-1:0] diff;

    fifo_gray2bin #(.WIDTH(PW)) u_wbin (.gray(wptr),     .bin(wbin));
    fifo_gray2bin #(.WIDTH(PW)) u_rbin (.gray(wq2_rptr), .bin(rbin));

    // Modular subtraction covers pointer wrap; a difference of 2**ADDR_SIZE is full.
    assign diff = wbin - rbin;

    // Registered level and almost-full flag.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wlevel       <= '0;
            walmost_full <= 1'b0;
        end else begin
            wlevel       <= diff;
            walmost_full <= (diff >= PW'(AFULL_THRESH));
        end
    end
`else
    logic unused_ptrs;
    assign unused_ptrs  = ^{wptr, wq2_rptr};
    assign wlevel       = '0;
    assign walmost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_ingress.sv
// Directed self-checking bench for fifo_wr_ingress.
module tb_fifo_wr_ingress;

    logic       wclk = 1'b0;
    logic       wrst_n;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       wfull;
    logic [4:0] wptr;
    logic [4:0] wq2_rptr;
    logic       winc;
    logic [7:0] wdata;
    logic [4:0] wlevel;
    logic       walmost_full;

    int checks = 0;
    int errors = 0;

    fifo_wr_ingress #(.ADDR_SIZE(4), .DATA_SIZE(8), .AFULL_THRESH(12)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .wfull(wfull), .wptr(wptr), .wq2_rptr(wq2_rptr),
        .winc(winc), .wdata(wdata), .wlevel(wlevel), .walmost_full(walmost_full)
    );

    always #5 wclk = ~wclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge.
    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    // Expected level outputs depend on the build option.
    task automatic check_level(input string tag, input logic [4:0] lvl, input logic af);
`ifdef FIFO_WR_AFULL_EN
        check({tag, "_wlevel"}, 32'(wlevel), 32'(lvl));
        check({tag, "_afull"},  32'(walmost_full), 32'(af));
`else
        check({tag, "_wlevel"}, 32'(wlevel), 32'd0);
        check({tag, "_afull"},  32'(walmost_full), 32'd0);
        if (lvl == 5'd31 && af) $display("unreachable");
`endif
    endtask

    initial begin
        // 1. Reset with a valid word presented.
        wrst_n = 1'b0; s_valid = 1'b1; s_data = 8'hAA; wfull = 1'b0;
        wptr = 5'd0; wq2_rptr = 5'd0;
        tick(); tick(); tick();
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_winc",    32'(winc), 32'd0);
        check_level("rst", 5'd0, 1'b0);
        wrst_n = 1'b1; s_valid = 1'b0;
        tick();
        check("post_rst_s_ready", 32'(s_ready), 32'd1);
        check("post_rst_winc",    32'(winc), 32'd0);

        // 2. Streaming 0x00..0x0F with no backpressure.
        s_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            s_data = 8'(k);
            #1;
            check("stream_s_ready", 32'(s_ready), 32'd1);
            if (k > 0) begin
                check("stream_winc",  32'(winc), 32'd1);
                check("stream_wdata", 32'(wdata), 32'(k - 1));
            end
            tick();
        end
        s_valid = 1'b0;
        #1;
        check("stream_last_winc",  32'(winc), 32'd1);
        check("stream_last_wdata", 32'(wdata), 32'h0F);
        tick();
        check("stream_empty_winc", 32'(winc), 32'd0);

        // 3. Backpressure: fill to 2 under wfull, then drain.
        wfull = 1'b1; s_valid = 1'b1; s_data = 8'h10;
        tick();
        check("bp1_winc",    32'(winc), 32'd0);
        check("bp1_s_ready", 32'(s_ready), 32'd1);
        check("bp1_wdata",   32'(wdata), 32'h10);
        s_data = 8'h11;
        tick();
        check("bp2_s_ready", 32'(s_ready), 32'd0);
        check("bp2_winc",    32'(winc), 32'd0);
        s_data = 8'h12;
        tick();
        check("bp3_s_ready", 32'(s_ready), 32'd0);
        check("bp3_wdata",   32'(wdata), 32'h10);
        wfull = 1'b0;
        #1;
        check("drain0_winc",  32'(winc), 32'd1);
        check("drain0_wdata", 32'(wdata), 32'h10);
        tick();
        check("drain1_winc",    32'(winc), 32'd1);
        check("drain1_wdata",   32'(wdata), 32'h11);
        check("drain1_s_ready", 32'(s_ready), 32'd1);
        tick();
        check("drain2_winc",  32'(winc), 32'd1);
        check("drain2_wdata", 32'(wdata), 32'h12);
        s_valid = 1'b0;
        tick();
        check("drain_empty_winc", 32'(winc), 32'd0);

        // 4. Push and pop together at count==1.
        wfull = 1'b1; s_valid = 1'b1; s_data = 8'h20;
        tick();
        wfull = 1'b0; s_data = 8'h21;
        #1;
        check("pp0_winc",  32'(winc), 32'd1);
        check("pp0_wdata", 32'(wdata), 32'h20);
        tick();
        s_valid = 1'b0;
        #1;
        check("pp1_winc",    32'(winc), 32'd1);
        check("pp1_wdata",   32'(wdata), 32'h21);
        check("pp1_s_ready", 32'(s_ready), 32'd1);
        tick();
        check("pp_empty_winc", 32'(winc), 32'd0);

        // Reset mid-operation discards a buffered word.
        wfull = 1'b1; s_valid = 1'b1; s_data = 8'h30;
        tick();
        s_valid = 1'b0; wrst_n = 1'b0;
        tick();
        wrst_n = 1'b1; wfull = 1'b0;
        #1;
        check("midrst_winc", 32'(winc), 32'd0);
        tick();
        check("midrst_winc2",   32'(winc), 32'd0);
        check("midrst_s_ready", 32'(s_ready), 32'd1);

        // 5. Level and almost-full threshold.
        wptr = gray(5'd13); wq2_rptr = gray(5'd1);
        tick();
        check_level("lvl12", 5'd12, 1'b1);
        wq2_rptr = gray(5'd2);
        tick();
        check_level("lvl11", 5'd11, 1'b0);

        // 6. Wrap-around and exactly-full difference.
        wptr = gray(5'd3); wq2_rptr = gray(5'd27);
        tick();
        check_level("wrap8", 5'd8, 1'b0);
        wptr = gray(5'd20); wq2_rptr = gray(5'd4);
        tick();
        check_level("full16", 5'd16, 1'b1);
        wptr = gray(5'd5); wq2_rptr = gray(5'd5);
        tick();
        check_level("empty0", 5'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
